// File: rtl/mem_pkg.sv
// Shared types and encodings for the RV32I memory stage: FSM states,
// result-source selects, load/store funct3 codes and the access-fault rule.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Misalignment depends only on the size bits; LHU shares LH's size code.
    function automatic logic mem_fault(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (is_store) illegal = (funct3 > F3_SW);
        else          illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return illegal | misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// load byte/half extraction with sign or zero extension, and fault detection.
module lsu_align import mem_pkg::*; (
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign o_fault = mem_fault(i_is_store, i_funct3, i_addr_lo);
    assign w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Sub-word stores replicate the datum so every enabled lane sees it.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_load_data = {24'h0, w_byte};
            F3_LHU:  o_load_data = {16'h0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// RV32I memory stage: EX/MEM register, ready/valid data-memory access FSM,
// load data latch and writeback presentation; stalls upstream while busy.
module memory_access import mem_pkg::*; #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_e,
    input  logic                     reg_write_e,
    input  logic                     mem_write_e,
    input  logic [1:0]               res_src_e,
    input  logic [2:0]               funct3_e,
    input  logic [DATA_WIDTH-1:0]    alu_result_e,
    input  logic [DATA_WIDTH-1:0]    write_data_e,
    input  logic [4:0]               rd_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [3:0]               dmem_be,
    output logic [DATA_WIDTH-1:0]    dmem_wdata,
    input  logic                     dmem_ready,
    input  logic                     dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]    dmem_rdata,
    output logic                     valid_m,
    output logic                     reg_write_m,
    output logic [1:0]               res_src_m,
    output logic [4:0]               rd_m,
    output logic [DATA_WIDTH-1:0]    alu_result_m,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
    output logic                     fault_m,
    output logic                     stall_m,
    output logic [1:0]               state_dbg
);

    // Handshake: a request transfers on any cycle where dmem_req & dmem_ready;
    // req and its address/be/wdata stay stable until then. A load response is
    // taken on dmem_rvalid only in WAIT, or in REQ together with dmem_ready.

    mem_state_t                r_state;
    logic                      r_valid;
    logic                      r_reg_write;
    logic                      r_mem_write;
    logic [1:0]                r_res_src;
    logic [2:0]                r_funct3;
    logic [DATA_WIDTH-1:0]     r_alu;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [4:0]                r_rd;
    logic [ADDRESS_WIDTH-1:0]  r_pc4;
    logic [DATA_WIDTH-1:0]     r_rdata;

    logic                      w_memop_e;
    logic                      w_fault_e;
    logic                      w_memop_r;
    logic                      w_req;
    logic [3:0]                w_be;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [DATA_WIDTH-1:0]     w_load_data;
    logic                      w_fault_r;

    // Capture-time fault check decides whether the FSM leaves IDLE at all.
    assign w_memop_e = valid_e & (mem_write_e | (res_src_e == RES_LOAD));
    assign w_fault_e = mem_fault(mem_write_e, funct3_e, alu_result_e[1:0]);
    assign w_memop_r = r_valid & (r_mem_write | (r_res_src == RES_LOAD));
    assign w_req     = (r_state == ST_REQ);

    lsu_align u_lsu_align (
        .i_is_store  (r_mem_write),
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_alu[1:0]),
        .i_wdata     (r_wdata),
        .i_rdata     (dmem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data),
        .o_fault     (w_fault_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_res_src   <= 2'b00;
            r_funct3    <= 3'b000;
            r_alu       <= '0;
            r_wdata     <= '0;
            r_rd        <= 5'd0;
            r_pc4       <= '0;
            r_rdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid     <= valid_e;
                    r_reg_write <= reg_write_e;
                    r_mem_write <= mem_write_e;
                    r_res_src   <= res_src_e;
                    r_funct3    <= funct3_e;
                    r_alu       <= alu_result_e;
                    r_wdata     <= write_data_e;
                    r_rd        <= rd_e;
                    r_pc4       <= pc_plus4_e;
                    r_rdata     <= '0;
                    if (w_memop_e && !w_fault_e) r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (dmem_ready) begin
                        if (r_mem_write) begin
                            r_state <= ST_IDLE;
                        end else if (dmem_rvalid) begin
                            r_rdata <= w_load_data;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        r_rdata <= w_load_data;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem_req     = w_req;
    assign dmem_we      = w_req & r_mem_write;
    assign dmem_addr    = w_req ? {r_alu[ADDRESS_WIDTH-1:2], 2'b00} : '0;
    assign dmem_be      = w_req ? w_be : 4'b0000;
    assign dmem_wdata   = w_req ? w_wdata : '0;

    // R is only ever seen in IDLE after the instruction has finished.
    assign stall_m      = (r_state != ST_IDLE);
    assign valid_m      = r_valid & (r_state == ST_IDLE);
    assign fault_m      = valid_m & w_memop_r & w_fault_r;
    assign reg_write_m  = valid_m & r_reg_write & ~fault_m;
    assign res_src_m    = r_res_src;
    assign rd_m         = r_rd;
    assign alu_result_m = r_alu;
    assign read_data_m  = r_rdata;
    assign pc_plus4_m   = r_pc4;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: hand-computed vectors for ALU, store,
// load, fault and reset-abandon cases, plus a completion scoreboard.
module tb_memory_access;

    logic        clk;
    logic        rst_n;
    logic        valid_e, reg_write_e, mem_write_e;
    logic [1:0]  res_src_e;
    logic [2:0]  funct3_e;
    logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
    logic [4:0]  rd_e;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        valid_m, reg_write_m, fault_m, stall_m;
    logic [1:0]  res_src_m, state_dbg;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m, read_data_m, pc_plus4_m;

    int          n_checks;
    int          n_fail;
    int          lat;
    int          stalls;
    logic [31:0] exp_q[$];

    memory_access #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_e      (valid_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .res_src_e    (res_src_e),
        .funct3_e     (funct3_e),
        .alu_result_e (alu_result_e),
        .write_data_e (write_data_e),
        .rd_e         (rd_e),
        .pc_plus4_e   (pc_plus4_e),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .res_src_m    (res_src_m),
        .rd_m         (rd_m),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .fault_m      (fault_m),
        .stall_m      (stall_m),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each completion carries the load data for clean loads,
    // otherwise the ALU result.
    always @(negedge clk) begin
        if (rst_n && valid_m) begin
            check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_eq("sb_result",
                         (res_src_m == 2'b01 && !fault_m) ? read_data_m : alu_result_m,
                         exp_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first cycle after the capture edge with a bubble on the EX inputs.
    task automatic issue(input logic mw, input logic rw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4);
        valid_e      = 1'b1;
        mem_write_e  = mw;
        reg_write_e  = rw;
        res_src_e    = rs;
        funct3_e     = f3;
        alu_result_e = addr;
        write_data_e = wd;
        rd_e         = rd;
        pc_plus4_e   = pc4;
        @(negedge clk);
        valid_e      = 1'b0;
    endtask

    // Memory model: ready in cycle rdy_dly+1 after capture, rvalid rv_gap
    // cycles after that (negative = never). Reports completion cycle/stalls.
    task automatic serve(input int rdy_dly, input int rv_gap, input logic [31:0] rdata,
                         output int o_lat, output int o_stalls);
        o_lat    = 0;
        o_stalls = 0;
        for (int c = 1; c <= 30; c++) begin
            if (valid_m) begin
                o_lat = c;
                break;
            end
            if (stall_m) o_stalls++;
            dmem_ready  = (c == rdy_dly + 1);
            dmem_rvalid = (rv_gap >= 0) && (c == rdy_dly + 1 + rv_gap);
            dmem_rdata  = dmem_rvalid ? rdata : 32'h0;
            @(negedge clk);
        end
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        valid_e = 1'b0; reg_write_e = 1'b0; mem_write_e = 1'b0;
        res_src_e = 2'b00; funct3_e = 3'b000; rd_e = 5'd0;
        alu_result_e = 32'h0; write_data_e = 32'h0; pc_plus4_e = 32'h0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

        repeat (3) @(negedge clk);
        check_eq("rst_valid_m", valid_m, 0);
        check_eq("rst_dmem_req", dmem_req, 0);
        check_eq("rst_stall_m", stall_m, 0);
        check_eq("rst_alu_result_m", alu_result_m, 0);
        check_eq("rst_read_data_m", read_data_m, 0);
        check_eq("rst_state", state_dbg, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD x5 = 0x1234
        exp_q.push_back(32'h1234);
        issue(1'b0, 1'b1, 2'b00, 3'b000, 32'h1234, 32'h0, 5'd5, 32'h8);
        check_eq("add_no_req", dmem_req, 0);
        serve(0, -1, 32'h0, lat, stalls);
        check_eq("add_latency", 32'(lat), 1);
        check_eq("add_reg_write_m", reg_write_m, 1);
        check_eq("add_rd_m", rd_m, 5);
        check_eq("add_stall_m", stall_m, 0);

        // SB 0xAB -> 0x103
        exp_q.push_back(32'h103);
        issue(1'b1, 1'b0, 2'b00, 3'b000, 32'h103, 32'h0000_00AB, 5'd0, 32'h0);
        check_eq("sb_req", dmem_req, 1);
        check_eq("sb_we", dmem_we, 1);
        check_eq("sb_addr", dmem_addr, 32'h100);
        check_eq("sb_be", 32'(dmem_be), 32'h8);
        check_eq("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check_eq("sb_stall", stall_m, 1);
        serve(0, -1, 32'h0, lat, stalls);
        check_eq("sb_latency", 32'(lat), 2);
        check_eq("sb_reg_write_m", reg_write_m, 0);

        // SH 0x1234ABCD -> 0x2
        exp_q.push_back(32'h2);
        issue(1'b1, 1'b0, 2'b00, 3'b001, 32'h2, 32'h1234_ABCD, 5'd0, 32'h0);
        check_eq("sh_be", 32'(dmem_be), 32'hC);
        check_eq("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        serve(1, -1, 32'h0, lat, stalls);
        check_eq("sh_latency", 32'(lat), 3);

        // SW 0xDEADBEEF -> 0x8
        exp_q.push_back(32'h8);
        issue(1'b1, 1'b0, 2'b00, 3'b010, 32'h8, 32'hDEAD_BEEF, 5'd0, 32'h0);
        check_eq("sw_be", 32'(dmem_be), 32'hF);
        check_eq("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        check_eq("sw_addr", dmem_addr, 32'h8);
        serve(0, -1, 32'h0, lat, stalls);
        check_eq("sw_latency", 32'(lat), 2);

        // LB from 0x102, ready delayed 2, rvalid one later
        exp_q.push_back(32'hFFFF_FF80);
        issue(1'b0, 1'b1, 2'b01, 3'b000, 32'h102, 32'h0, 5'd7, 32'h0);
        check_eq("lb_req", dmem_req, 1);
        check_eq("lb_we", dmem_we, 0);
        check_eq("lb_addr", dmem_addr, 32'h100);
        serve(2, 1, 32'h0080_0000, lat, stalls);
        check_eq("lb_stall_cycles", 32'(stalls), 4);
        check_eq("lb_latency", 32'(lat), 5);
        check_eq("lb_data", read_data_m, 32'hFFFF_FF80);
        check_eq("lb_reg_write_m", reg_write_m, 1);
        check_eq("lb_rd_m", rd_m, 7);

        // LBU same access
        exp_q.push_back(32'h0000_0080);
        issue(1'b0, 1'b1, 2'b01, 3'b100, 32'h102, 32'h0, 5'd8, 32'h0);
        serve(2, 1, 32'h0080_0000, lat, stalls);
        check_eq("lbu_stall_cycles", 32'(stalls), 4);
        check_eq("lbu_data", read_data_m, 32'h0000_0080);

        // LW misaligned -> fault, no request
        exp_q.push_back(32'h202);
        issue(1'b0, 1'b1, 2'b01, 3'b010, 32'h202, 32'h0, 5'd9, 32'h0);
        check_eq("lwmis_no_req", dmem_req, 0);
        check_eq("lwmis_valid_m", valid_m, 1);
        check_eq("lwmis_fault_m", fault_m, 1);
        check_eq("lwmis_reg_write_m", reg_write_m, 0);
        check_eq("lwmis_stall", stall_m, 0);
        serve(0, -1, 32'h0, lat, stalls);

        // SH misaligned and store with illegal funct3
        exp_q.push_back(32'h11);
        issue(1'b1, 1'b0, 2'b00, 3'b001, 32'h11, 32'h5555, 5'd0, 32'h0);
        check_eq("shmis_no_req", dmem_req, 0);
        check_eq("shmis_fault_m", fault_m, 1);
        serve(0, -1, 32'h0, lat, stalls);
        exp_q.push_back(32'h20);
        issue(1'b1, 1'b0, 2'b00, 3'b011, 32'h20, 32'h5555, 5'd0, 32'h0);
        check_eq("sbad_no_req", dmem_req, 0);
        check_eq("sbad_fault_m", fault_m, 1);
        serve(0, -1, 32'h0, lat, stalls);

        // LH from 0x4, ready + rvalid together
        exp_q.push_back(32'h0000_7FFF);
        issue(1'b0, 1'b1, 2'b01, 3'b001, 32'h4, 32'h0, 5'd10, 32'h0);
        serve(0, 0, 32'h8001_7FFF, lat, stalls);
        check_eq("lh_latency", 32'(lat), 2);
        check_eq("lh_stall_cycles", 32'(stalls), 1);
        check_eq("lh_data", read_data_m, 32'h0000_7FFF);
        check_eq("lh_fault_m", fault_m, 0);

        // LHU upper half from 0x6
        exp_q.push_back(32'h0000_8001);
        issue(1'b0, 1'b1, 2'b01, 3'b101, 32'h6, 32'h0, 5'd11, 32'h0);
        serve(0, 1, 32'h8001_7FFF, lat, stalls);
        check_eq("lhu_latency", 32'(lat), 3);
        check_eq("lhu_data", read_data_m, 32'h0000_8001);

        // pc+4 writeback
        exp_q.push_back(32'h77);
        issue(1'b0, 1'b1, 2'b10, 3'b000, 32'h77, 32'h0, 5'd1, 32'h44);
        serve(0, -1, 32'h0, lat, stalls);
        check_eq("jal_pc_plus4_m", pc_plus4_m, 32'h44);
        check_eq("jal_res_src_m", 32'(res_src_m), 2);

        // Reset while WAIT: access abandoned, late rvalid ignored
        issue(1'b0, 1'b1, 2'b01, 3'b010, 32'h10, 32'h0, 5'd3, 32'h0);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        check_eq("wait_stall", stall_m, 1);
        check_eq("wait_state", state_dbg, 2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_dmem_req", dmem_req, 0);
        check_eq("arst_stall_m", stall_m, 0);
        check_eq("arst_valid_m", valid_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        check_eq("late_rvalid_valid_m", valid_m, 0);
        check_eq("late_rvalid_stall_m", stall_m, 0);
        check_eq("late_rvalid_data", read_data_m, 0);

        exp_q.push_back(32'h55);
        issue(1'b0, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 5'd4, 32'h0);
        serve(0, -1, 32'h0, lat, stalls);
        check_eq("post_rst_latency", 32'(lat), 1);
        check_eq("post_rst_reg_write_m", reg_write_m, 1);

        @(negedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
